vector8_sequencer: RTL
======================

Name: vector8_sequencer

Overview:
- Fetch/decode/execute controller for the Vector-8 datapath; the initiating side of the ALU interface.
- Fetches two-byte instructions from a synchronous 256-byte memory.
- Drives opcode and operands into the 8-bit ALU, then writes the result back to the accumulator and zero flag.
- Implements store, jump, conditional jump and halt itself.

Parameters:
- RESET_PC, 8'h00, program counter value loaded on reset.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  advance enable; when 0 all state holds (stall).
- mem_addr  output  8  memory address.
- mem_rdata  input  8  memory read data; valid the cycle after mem_addr is presented (1-cycle synchronous read).
- mem_wdata  output  8  memory write data.
- mem_we  output  1  write strobe, one cycle.
- alu_opcode  output  5  opcode to the ALU (= ir).
- alu_a  output  8  ALU A operand (= acc).
- alu_b  output  8  ALU data operand (= arg).
- alu_out  input  8  ALU result (combinational).
- alu_zero  input  1  ALU zero (combinational).
- acc_out  output  8  accumulator, for debug.
- pc_out  output  8  program counter.
- zflag  output  1  registered zero flag.
- halted  output  1  high in HALT state.

Behaviour:
- Reset (async, immediate): state=FETCH, pc=RESET_PC, ir=0, arg=0, acc=0, zflag=0, halted=0.
  - Outputs under reset: mem_we=0, mem_wdata=0, mem_addr=RESET_PC.
- Instruction format: byte0 = opcode (bits [4:0] used, [7:5] ignored); byte1 = operand/address. Every instruction is two bytes.
- FSM, one transition per clk with run=1; run=0 holds state and all registers, and mem_we=0.
  - FETCH: mem_addr=pc; pc<=pc+1 -> LOAD_OP.
  - LOAD_OP: ir<=mem_rdata[4:0]; mem_addr=pc; pc<=pc+1 -> LOAD_ARG.
  - LOAD_ARG: arg<=mem_rdata -> EXEC.
  - EXEC: act on ir, then -> FETCH (or HALT).
  - HALT: halted=1; stays until rst. run is ignored.
- Each instruction takes 4 active cycles.
- EXEC actions:
  - 0x01..0x0C (ALU ops): acc<=alu_out; zflag<=alu_zero. The operand byte is ignored by unary ops, but arg is still loaded.
  - 0x10 STA: mem_addr=arg, mem_wdata=acc, mem_we=1 for exactly this cycle. acc and zflag unchanged.
  - 0x11 JMP: pc<=arg.
  - 0x12 JZ: pc<=arg if zflag=1, else pc unchanged (already points at the next instruction).
  - 0x1F HLT: -> HALT.
  - 0x00 and all other codes: NOP, no register change.
- mem_addr is pc in all states except EXEC-STA. mem_wdata=acc whenever mem_we=1, else 0.
- alu_opcode=ir, alu_a=acc, alu_b=arg at all times; results are captured only in EXEC.
- zflag is updated only by ALU ops; STA, JMP, JZ and NOP preserve it.
- pc arithmetic is mod 256:
  - 8'hFF+1 wraps to 8'h00.
  - An opcode at 0xFF takes its operand from 0x00.
- Reset mid-instruction: the in-flight instruction is abandoned, with no partial write-back. A mem_we pulse in progress is deasserted immediately.
- run deasserted in EXEC: the action is deferred, not lost, and executes on the first cycle run=1.

Test Plan:
- Basic program: mem 00:01 05, 02:02 03, 04:10 80, 06:1F xx; rst then run=1.
  - mem_we=1 with mem_addr=0x80 and mem_wdata=0x08 on active cycle 12.
  - halted=1 from cycle 17; acc=0x08, zflag=0.
- Zero/JZ taken: mem 00:01 04, 02:03 04, 04:12 0A, 06:01 FF, 0A:1F.
  - After SUB: acc=0x00, zflag=1.
  - JZ sets pc=0x0A; the LDA 0xFF at 06 never executes; halt with acc=0x00.
- JZ not taken and flag preservation: LDA 01, STA 40, JZ 20, LDA 7E, HLT.
  - zflag stays 0 across STA; fallthrough; final acc=0x7E.
- Wrap: RESET_PC=8'hFE, mem FE:0B (INC), 00:1F.
  - Operand read from 0xFF; pc wraps to 0x00; halt with acc=0x01.
- Stall: drop run for 3 cycles during the EXEC of STA.
  - mem_we=0 while stalled; exactly one mem_we pulse after run returns; memory contents identical to the unstalled run.
- Async reset mid-STA: assert rst between clock edges while mem_we=1.
  - mem_we falls immediately; pc=RESET_PC, acc=0, halted=0; the program restarts cleanly after rst is released.

Source files
------------

// File: rtl/vector8_sequencer.sv
// Vector-8 fetch/decode/execute sequencer: fetches two-byte instructions from a
// synchronous memory, drives the external ALU and performs store/jump/halt itself.
module vector8_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic [4:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  output logic [7:0] acc_out,
  output logic [7:0] pc_out,
  output logic       zflag,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_LOAD_OP,
    S_LOAD_ARG,
    S_EXEC,
    S_HALT
  } state_e;

  localparam logic [4:0] OP_ALU_LO = 5'h01;
  localparam logic [4:0] OP_ALU_HI = 5'h0C;
  localparam logic [4:0] OP_STA    = 5'h10;
  localparam logic [4:0] OP_JMP    = 5'h11;
  localparam logic [4:0] OP_JZ     = 5'h12;
  localparam logic [4:0] OP_HLT    = 5'h1F;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [4:0] ir_q, ir_d;
  logic [7:0] arg_q, arg_d;
  logic [7:0] acc_q, acc_d;
  logic       zflag_q, zflag_d;
  logic       halted_q, halted_d;
  logic       sta_exec;

  assign sta_exec = (state_q == S_EXEC) && (ir_q == OP_STA);

  // A stalled STA keeps its address on the bus but must not strobe the write.
  assign mem_we    = sta_exec && run;
  assign mem_addr  = sta_exec ? arg_q : pc_q;
  assign mem_wdata = mem_we ? acc_q : 8'h00;

  assign alu_opcode = ir_q;
  assign alu_a      = acc_q;
  assign alu_b      = arg_q;
  assign acc_out    = acc_q;
  assign pc_out     = pc_q;
  assign zflag      = zflag_q;
  assign halted     = halted_q;

  always_comb begin
    // NOTE: every _d starts as its _q so no branch below can leave one unassigned and infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    arg_d    = arg_q;
    acc_d    = acc_q;
    zflag_d  = zflag_q;
    halted_d = halted_q;
    if (run) begin
      case (state_q)
        S_FETCH: begin
          pc_d    = pc_q + 8'd1;
          state_d = S_LOAD_OP;
        end
        S_LOAD_OP: begin
          ir_d    = mem_rdata[4:0];
          pc_d    = pc_q + 8'd1;
          state_d = S_LOAD_ARG;
        end
        S_LOAD_ARG: begin
          arg_d   = mem_rdata;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          state_d = S_FETCH;
          if (ir_q inside {[OP_ALU_LO:OP_ALU_HI]}) begin
            acc_d   = alu_out;
            zflag_d = alu_zero;
          end else if (ir_q == OP_JMP) begin
            pc_d = arg_q;
          end else if (ir_q == OP_JZ) begin
            if (zflag_q) pc_d = arg_q;
          end else if (ir_q == OP_HLT) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
        end
        default: ; // S_HALT only leaves through reset
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 5'h00;
      arg_q    <= 8'h00;
      acc_q    <= 8'h00;
      zflag_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      arg_q    <= arg_d;
      acc_q    <= acc_d;
      zflag_q  <= zflag_d;
      halted_q <= halted_d;
    end
  end

endmodule
